// File: rtl/tdc_thermo_encoder.sv
// ---------------------------------------------------------------------------
// tdc_thermo_encoder
//
// Capture-and-encode stage that sits directly behind a CARRY4 delay line.
// The raw tap bus is registered every clock (two stages). The hit FSM watches
// the first tap of the second stage, so each delay-line pulse yields exactly
// one hit. The hit carries a bubble-tolerant fine count (the popcount of the
// taps) and the coarse cycle count that was sampled together with the taps.
// Timestamps leave through a single-entry valid/ready output register. Hits
// that arrive while that register is stalled are dropped and counted.
//
// Ports
//   clk         single clock
//   rst_n       synchronous, active-low reset
//   taps        raw carry-out bus (asynchronous to clk), bit 0 = first tap
//   enable      arms hit detection and runs the coarse counter
//   out_valid   timestamp available
//   out_ready   consumer accepts the timestamp
//   out_fine    number of ones in the captured taps
//   out_coarse  coarse count registered together with the taps
//   out_sat     every tap was 1 at capture (fine value overflowed)
//   drop_cnt    hits lost to backpressure, saturating
//   overflow    sticky, set on the first dropped hit
// ---------------------------------------------------------------------------
module tdc_thermo_encoder #(
  parameter int NCARRY4  = 2,
  parameter int COARSE_W = 16,
  parameter int FINE_W   = $clog2(4*NCARRY4+1),
  parameter int DROP_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NCARRY4-1:0]   taps,
  input  logic                   enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FINE_W-1:0]      out_fine,
  output logic [COARSE_W-1:0]    out_coarse,
  output logic                   out_sat,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   overflow
);

  localparam int NTAPS = 4*NCARRY4;

  typedef enum logic {
    ARMED      = 1'b0,
    WAIT_CLEAR = 1'b1
  } state_t;

  // Counts ones anywhere in the word, so bubbles in the thermometer code
  // do not matter.
  function automatic logic [FINE_W-1:0] popcount(input logic [NTAPS-1:0] v);
    logic [FINE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NTAPS; i++) begin
      cnt = cnt + FINE_W'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // Sampling registers. r_s1 is the metastability-capture stage: constrain it
  // ASYNC_REG and place it next to the CARRY4 cells.
  (* ASYNC_REG = "TRUE" *) logic [NTAPS-1:0] r_s1;
  (* ASYNC_REG = "TRUE" *) logic [NTAPS-1:0] r_s2;
  logic [COARSE_W-1:0] r_coarse;
  logic [COARSE_W-1:0] r_c1;
  logic [COARSE_W-1:0] r_c2;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_hit;

  logic [FINE_W-1:0]   w_fine;
  logic                w_sat;
  logic                w_load;
  logic                w_drop;

  logic                r_out_valid;
  logic [FINE_W-1:0]   r_out_fine;
  logic [COARSE_W-1:0] r_out_coarse;
  logic                r_out_sat;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic                r_overflow;

  // --- stage 0/1: capture taps and coarse count side by side ---
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_c1     <= '0;
      r_c2     <= '0;
      r_coarse <= '0;
    end else begin
      r_s1 <= taps;
      r_s2 <= r_s1;
      r_c1 <= r_coarse;
      r_c2 <= r_c1;
      if (enable) begin
        r_coarse <= r_coarse + COARSE_W'(1);
      end
    end
  end

  // --- stage 2: hit detection and encoding on r_s2 ---
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    case (r_state)
      ARMED: begin
        if (r_s2[0] && enable) begin
          w_hit       = 1'b1;
          w_state_nxt = WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: begin
        // Stay here while the line is still filled so a long pulse
        // produces only one hit.
        if (!r_s2[0]) begin
          w_state_nxt = ARMED;
        end
      end
      default: begin
        w_state_nxt = ARMED;
      end
    endcase
  end

  assign w_fine = popcount(r_s2);
  assign w_sat  = &r_s2;

  // A hit is taken when the slot is empty or being drained this cycle;
  // otherwise it is dropped and the held timestamp is left alone.
  assign w_load = w_hit && (!r_out_valid || out_ready);
  assign w_drop = w_hit && r_out_valid && !out_ready;

  // --- stage 3: single-entry output register ---
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_fine   <= '0;
      r_out_coarse <= '0;
      r_out_sat    <= 1'b0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_fine   <= w_fine;
        r_out_coarse <= r_c2;
        r_out_sat    <= w_sat;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_fine   = r_out_fine;
  assign out_coarse = r_out_coarse;
  assign out_sat    = r_out_sat;
  assign drop_cnt   = r_drop_cnt;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_tdc_thermo_encoder.sv
// ---------------------------------------------------------------------------
// tb_tdc_thermo_encoder
//
// Scoreboard bench for tdc_thermo_encoder (NCARRY4=2, COARSE_W=8). Stimulus
// pushes the hand-computed timestamp for each hit that must appear; a monitor
// pops and compares on every accepted output and checks that a stalled
// output holds its data.
// ---------------------------------------------------------------------------
module tb_tdc_thermo_encoder;

  localparam int NCARRY4  = 2;
  localparam int COARSE_W = 8;
  localparam int FINE_W   = 4;
  localparam int DROP_W   = 8;

  logic                clk;
  logic                rst_n;
  logic [7:0]          taps;
  logic                enable;
  logic                out_valid;
  logic                out_ready;
  logic [FINE_W-1:0]   out_fine;
  logic [COARSE_W-1:0] out_coarse;
  logic                out_sat;
  logic [DROP_W-1:0]   drop_cnt;
  logic                overflow;

  tdc_thermo_encoder #(
    .NCARRY4 (NCARRY4),
    .COARSE_W(COARSE_W),
    .FINE_W  (FINE_W),
    .DROP_W  (DROP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .taps      (taps),
    .enable    (enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fine  (out_fine),
    .out_coarse(out_coarse),
    .out_sat   (out_sat),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FINE_W-1:0]   fine;
    logic [COARSE_W-1:0] coarse;
    logic                sat;
    int                  cyc;   // required cycle of first presentation, -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [COARSE_W-1:0] cm;   // reference coarse counter

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n)      cm <= '0;
    else if (enable) cm <= cm + 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_hit(input logic [FINE_W-1:0] f, input logic [COARSE_W-1:0] c,
                            input logic s, input int at_cyc);
    exp_t e;
    e.fine = f; e.coarse = c; e.sat = s; e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [7:0] v, input int len, input int gap);
    taps = v;
    tick(len);
    taps = 8'h00;
    tick(gap);
  endtask

  // Monitor: compares every accepted output and checks hold-while-stalled.
  initial begin
    exp_t e;
    logic hold_prev;
    logic [FINE_W+COARSE_W:0] held;
    hold_prev = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (out_valid && hold_prev) begin
        chk("stall_hold", {out_fine, out_coarse, out_sat}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual fine=%0d coarse=%0d required none",
                   out_fine, out_coarse);
        end else begin
          e = exp_q.pop_front();
          chk("out_fine", out_fine, e.fine);
          chk("out_coarse", out_coarse, e.coarse);
          chk("out_sat", out_sat, e.sat);
          if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = {out_fine, out_coarse, out_sat};
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_fine"}, out_fine, 0);
    chk({tag, "_coarse"}, out_coarse, 0);
    chk({tag, "_sat"}, out_sat, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    taps      = 8'h00;
    enable    = 1'b1;
    out_ready = 1'b1;
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Basic thermometer: 3 taps filled for 3 cycles, one output 2 cycles after E0.
    expect_hit(4'd3, cm, 1'b0, cyc + 3);
    pulse(8'b0000_0111, 3, 6);

    // Bubble in the code: popcount 4, single output.
    expect_hit(4'd4, cm, 1'b0, -1);
    pulse(8'b0010_1011, 2, 6);

    // Full line: fine = 8 and saturation flag.
    expect_hit(4'd8, cm, 1'b1, -1);
    pulse(8'hFF, 1, 6);

    // Back-to-back hits at minimum spacing with out_ready=1: both delivered.
    expect_hit(4'd1, cm, 1'b0, -1);
    pulse(8'h01, 1, 1);
    expect_hit(4'd2, cm, 1'b0, -1);
    pulse(8'h03, 1, 6);

    // Backpressure: first hit held, next two dropped.
    out_ready = 1'b0;
    expect_hit(4'd1, cm, 1'b0, -1);
    pulse(8'h01, 1, 4);
    pulse(8'h03, 1, 4);
    pulse(8'h07, 1, 4);
    chk("bp_valid", out_valid, 1);
    chk("bp_fine", out_fine, 1);
    chk("bp_drop_cnt", drop_cnt, 2);
    chk("bp_overflow", overflow, 1);
    out_ready = 1'b1;
    tick(1);
    chk("bp_valid_falls", out_valid, 0);
    tick(2);

    // enable=0 across a pulse: no hit.
    enable = 1'b0;
    pulse(8'h0F, 2, 2);
    enable = 1'b1;
    tick(6);
    chk("disabled_no_valid", out_valid, 0);

    // Reset between capture (E0) and E2: hit discarded, everything cleared.
    taps = 8'h07;
    tick(1);
    taps  = 8'h00;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    chk_all_zero("midreset");

    // Coarse wrap: 300 enabled cycles after reset, 300 mod 256 = 44.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(300);
    expect_hit(4'd5, 8'd44, 1'b0, -1);
    pulse(8'h1F, 1, 6);

    // Drain: bounded wait for every expected output.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
